serial_word_rx: RTL and testbench

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

---
 rtl/link_pkg.sv | 19 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/serial_word_rx.sv | 147 ++++++++++++++
 tb/tb_serial_word_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the serial link: receiver FSM states, default sizes
// and the bit positions inside err_flags.
package link_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // err_flags = {overflow, frame_err, parity_err}
  localparam int ERR_PARITY   = 0;
  localparam int ERR_FRAME    = 1;
  localparam int ERR_OVERFLOW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a pop and a push may share a
// cycle even when full, which keeps the level constant.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  // Head reads as zero when empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and level alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Receives MSB-first serial frames framed by com_en, validates length and
// even parity, and queues good payloads in an output FIFO.
module serial_word_rx
  import link_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PARITY_EN = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       com_en,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [2:0]                 err_flags,
  output logic [7:0]                 err_count,
  input  logic                       clear_err
);

  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] SAT_CNT = CW'(N + 1);

  logic [1:0]    din_sync;
  logic [1:0]    en_sync;
  logic          din_s;
  logic          en_s;
  rx_state_e     state;
  rx_state_e     state_next;
  logic          capture;
  logic          check_now;
  logic [CW-1:0] bcnt;
  logic [N-1:0]  shreg;
  logic          len_ok;
  logic          par_ok;
  logic          good;
  logic          pop_fire;
  logic          dropped;
  logic          fifo_empty;
  logic          fifo_full;
  logic [2:0]    new_err;

  // Both lines cross from the remote board's clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      din_sync <= '0;
      en_sync  <= '0;
    end else begin
      din_sync <= {din_sync[0], data_in};
      en_sync  <= {en_sync[0], com_en};
    end
  end

  assign din_s = din_sync[1];
  assign en_s  = en_sync[1];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    check_now  = 1'b0;
    case (state)
      IDLE: begin
        if (en_s) begin
          state_next = SHIFT;
          capture    = 1'b1;
        end
      end
      SHIFT: begin
        if (en_s) capture    = 1'b1;
        else      state_next = CHECK;
      end
      CHECK: begin
        check_now  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bits past N are not stored; the counter parks at N+1 to mark an over-long frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt  <= '0;
      shreg <= '0;
    end else if (check_now) begin
      bcnt <= '0;
    end else if (capture) begin
      if (bcnt < N_CNT)    shreg <= {shreg[N-2:0], din_s};
      if (bcnt != SAT_CNT) bcnt  <= bcnt + CW'(1);
    end
  end

  assign len_ok   = (bcnt == N_CNT);
  assign par_ok   = (PARITY_EN == 0) || !(^shreg);
  assign good     = check_now && len_ok && par_ok;
  assign pop_fire = out_valid && out_ready;
  assign dropped  = good && fifo_full && !pop_fire;

  always_comb begin
    new_err               = '0;
    new_err[ERR_FRAME]    = check_now && !len_ok;
    new_err[ERR_PARITY]   = check_now && len_ok && !par_ok;
    new_err[ERR_OVERFLOW] = dropped;
  end

  // A clear coinciding with a fresh error keeps the fresh error.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_flags <= '0;
      err_count <= '0;
    end else if (clear_err) begin
      err_flags <= new_err;
      err_count <= (|new_err) ? 8'd1 : 8'd0;
    end else begin
      err_flags <= err_flags | new_err;
      if ((|new_err) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (good),
    .push_data (shreg[N-1 -: WIDTH]),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed scenarios plus random
// frames compared against a frame-level queue model.
module tb_serial_word_rx;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 4;
  localparam int PARITY_EN = 1;
  localparam int NB        = WIDTH + PARITY_EN;

  logic             clock = 1'b0;
  logic             reset;
  logic             data_in;
  logic             com_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       fifo_level;
  logic [2:0]       err_flags;
  logic [7:0]       err_count;
  logic             clear_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [2:0]       exp_flags;
  int               exp_count;

  serial_word_rx #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PARITY_EN (PARITY_EN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .com_en     (com_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .err_flags  (err_flags),
    .err_count  (err_count),
    .clear_err  (clear_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [31:0] p, input bit bad_par);
    return {31'b0, p, (^p) ^ bad_par};
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_lvl"},   fifo_level, 64'(exp_q.size()));
    check({tag, "_vld"},   out_valid,  64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_dat"}, out_data, exp_q[0]);
    check({tag, "_flags"}, err_flags,  exp_flags);
    check({tag, "_cnt"},   err_count,  64'(exp_count));
  endtask

  // Sends nbits of 'bits' MSB first. The 2-flop synchronizer plus the
  // IDLE/SHIFT/CHECK sequence put the CHECK cycle three edges after com_en
  // falls; pop/clear pulses land on that cycle. rst_at >= 0 resets at that bit.
  task automatic send_frame(input string tag, input logic [63:0] bits, input int nbits,
                            input bit pop_chk, input bit clr_chk, input int rst_at);
    bit         rst_hit = 0;
    logic [2:0] err     = '0;
    for (int i = 0; i < nbits; i++) begin
      com_en  = 1'b1;
      data_in = bits[nbits-1-i];
      if (i == rst_at) reset = 1'b1;
      @(posedge clock); #1;
      if (i == rst_at) begin
        reset   = 1'b0;
        rst_hit = 1;
        exp_q.delete();
        exp_flags = '0;
        exp_count = 0;
        check({tag, "_rst_vld"},   out_valid,  0);
        check({tag, "_rst_dat"},   out_data,   0);
        check({tag, "_rst_lvl"},   fifo_level, 0);
        check({tag, "_rst_flags"}, err_flags,  0);
        check({tag, "_rst_cnt"},   err_count,  0);
      end
    end
    com_en  = 1'b0;
    data_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_pre_vld"}, out_valid, 64'(exp_q.size() != 0));
    if (pop_chk && exp_q.size() != 0) check({tag, "_pop_dat"}, out_data, exp_q[0]);
    out_ready = pop_chk;
    clear_err = clr_chk;
    @(posedge clock); #1;
    out_ready = 1'b0;
    clear_err = 1'b0;
    if (pop_chk && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rst_hit || nbits != NB)   err[1] = 1'b1;
    else if (^bits[NB-1:0])       err[0] = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(bits[NB-1:1]);
    else                          err[2] = 1'b1;
    if (clr_chk) begin
      exp_flags = err;
      exp_count = (err != 0) ? 1 : 0;
    end else begin
      exp_flags = exp_flags | err;
      if (err != 0 && exp_count < 255) exp_count++;
    end
    check_model(tag);
    @(posedge clock); #1;
  endtask

  task automatic drain(input string tag);
    int n = exp_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_drain_vld"}, out_valid, 1);
      check({tag, "_drain_dat"}, out_data,  exp_q.pop_front());
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    check({tag, "_empty_vld"}, out_valid,  0);
    check({tag, "_empty_lvl"}, fifo_level, 0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clock); #1;
    clear_err = 1'b0;
    exp_flags = '0;
    exp_count = 0;
    check("clr_flags", err_flags, 0);
    check("clr_cnt",   err_count, 0);
  endtask

  initial begin
    logic [63:0] bits;
    logic [31:0] p;
    int          kind;
    int          nb;

    reset     = 1'b1;
    data_in   = 1'b0;
    com_en    = 1'b0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    exp_flags = '0;
    exp_count = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_vld",   out_valid,  0);
    check("reset_dat",   out_data,   0);
    check("reset_lvl",   fifo_level, 0);
    check("reset_flags", err_flags,  0);
    check("reset_cnt",   err_count,  0);

    // Good frame, then the same payload with the wrong parity bit
    send_frame("good_dead", frame_of(32'hDEADBEEF, 0), NB, 0, 0, -1);
    drain("good_dead");
    send_frame("bad_par", frame_of(32'hDEADBEEF, 1), NB, 0, 0, -1);
    check("bad_par_flags_lit", err_flags, 3'b001);
    pulse_clear();

    // Short and long frames
    bits = {$urandom(), $urandom()};
    send_frame("short31", bits, 31, 0, 0, -1);
    send_frame("long35",  bits, 35, 0, 0, -1);
    check("len_flags_lit", err_flags, 3'b010);
    check("len_cnt_lit",   err_count, 2);
    pulse_clear();

    // Overflow: five good frames with nobody reading
    for (int i = 1; i <= 5; i++) send_frame("ovf", frame_of(32'(i), 0), NB, 0, 0, -1);
    check("ovf_lvl_lit",   fifo_level, DEPTH);
    check("ovf_flags_lit", err_flags,  3'b100);
    drain("ovf");
    pulse_clear();

    // Full FIFO with a pop on the CHECK cycle of the fifth frame
    for (int i = 11; i <= 14; i++) send_frame("fullpop", frame_of(32'(i), 0), NB, 0, 0, -1);
    send_frame("fullpop5", frame_of(32'd15, 0), NB, 1, 0, -1);
    check("fullpop_lvl_lit",   fifo_level, DEPTH);
    check("fullpop_flags_lit", err_flags,  0);
    drain("fullpop");

    // Clear coinciding with a new error: the new error wins
    send_frame("pre_clr", bits, 20, 0, 0, -1);
    send_frame("clr_hit", frame_of(32'h0F0F1234, 1), NB, 0, 1, -1);
    check("clr_hit_flags_lit", err_flags, 3'b001);
    check("clr_hit_cnt_lit",   err_count, 1);

    // Reset at bit 10 with a word queued and errors pending
    send_frame("pre_rst", frame_of(32'hA5A5_0001, 0), NB, 0, 0, -1);
    send_frame("mid_rst", frame_of(32'hCAFEF00D, 0), NB, 0, 0, 10);
    check("mid_rst_flags_lit", err_flags, 3'b010);
    send_frame("post_rst", frame_of(32'h12345678, 0), NB, 0, 0, -1);
    drain("post_rst");

    // Random traffic
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      p    = $urandom();
      nb   = NB;
      if (kind <= 5) bits = frame_of(p, 0);
      else if (kind <= 7) bits = frame_of(p, 1);
      else begin
        bits = {$urandom(), $urandom()};
        nb   = $urandom_range(8, 40);
        if (nb == NB) nb = NB + 1;
      end
      send_frame("rnd", bits, nb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), -1);
      if ($urandom_range(0, 3) == 0) drain("rnd");
    end
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
